// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB master bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // A TIMEOUT of this value turns the access timeout off.
    localparam int TIMEOUT_DISABLED = 0;

    // Width of the slave index; never less than one bit.
    function automatic int apb_sel_w(input int nslv);
        return (nslv > 1) ? $clog2(nslv) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Address-to-slave decoder: the top bits of the address pick the slave,
// which is returned both as an index and as a one-hot select vector.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int AW   = 9,
    parameter int NSLV = 2
) (
    input  logic [AW-1:0]               addr,
    output logic [apb_sel_w(NSLV)-1:0]  sel,
    output logic [NSLV-1:0]             psel_oh
);

    localparam int SW = apb_sel_w(NSLV);

    // Offset bits inside a slave window play no part in the decode.
    logic unused_offset;
    assign unused_offset = ^addr[AW-SW-1:0];

    assign sel = addr[AW-1 -: SW];

    // One-hot expansion of the slave index.
    always_comb begin
        psel_oh      = '0;
        psel_oh[sel] = 1'b1;
    end

endmodule

// File: rtl/apb_master_nslv.sv
// APB3 master bridge: takes single requests on a valid/ready port, runs
// them as SETUP/ACCESS transfers on one of NSLV slaves, and reports each
// completion (or timeout abort) as a one-cycle registered response.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | no transfer outstanding, req_ready high
//  SETUP  | PSEL asserted, PENABLE low, address/data presented
//  ACCESS | PENABLE high, waiting on PREADY of the selected slave
module apb_master_nslv
    import apb_pkg::*;
#(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int NSLV    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AW-1:0]        req_addr,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic [NSLV-1:0]      PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [AW-1:0]        PADDR,
    output logic [DW-1:0]        PWDATA,
    input  logic [NSLV*DW-1:0]   PRDATA,
    input  logic [NSLV-1:0]      PREADY,
    input  logic [NSLV-1:0]      PSLVERR
);

    localparam int SW      = apb_sel_w(NSLV);
    // A disabled timeout still gets a one-bit counter so the logic stays legal.
    localparam int WCW     = (TIMEOUT == TIMEOUT_DISABLED) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST = (TIMEOUT == TIMEOUT_DISABLED) ? 0 : TIMEOUT - 1;
    localparam logic [WCW-1:0] WC_MAX  = '1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(TO_LAST);

    apb_state_t      state_q;
    apb_state_t      state_d;
    logic [WCW-1:0]  wait_cnt;
    logic [SW-1:0]   sel;
    logic [NSLV-1:0] psel_oh;
    logic            hs;
    logic            sel_ready;
    logic            sel_err;
    logic [DW-1:0]   sel_rdata;
    logic            done;
    logic            abort;

    // PADDR holds the latched request, so decoding it gives the latched slave.
    apb_addr_decode #(
        .AW   (AW),
        .NSLV (NSLV)
    ) u_addr_decode (
        .addr    (PADDR),
        .sel     (sel),
        .psel_oh (psel_oh)
    );

    assign sel_ready = PREADY[sel];
    assign sel_err   = PSLVERR[sel];
    assign sel_rdata = PRDATA[int'(sel)*DW +: DW];

    assign req_ready = (state_q == IDLE) && !PRST;
    assign hs        = req_valid && req_ready;
    assign PSEL      = (state_q == IDLE) ? '0 : psel_oh;
    assign PENABLE   = (state_q == ACCESS);

    // Next-state decode plus completion/abort strobes.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if ((TIMEOUT != TIMEOUT_DISABLED) && (wait_cnt == WC_LAST)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Latch the accepted request onto the APB address/data lines; they hold while idle.
    always_ff @(posedge PCLK) begin
        if (PRST) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (hs) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_write ? req_wdata : '0;
        end
    end

    // Count wait cycles in ACCESS; cleared on the way into SETUP, saturating.
    always_ff @(posedge PCLK) begin
        if (PRST) begin
            wait_cnt <= '0;
        end else if (hs) begin
            wait_cnt <= '0;
        end else if ((state_q == ACCESS) && !sel_ready && (wait_cnt != WC_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Registered response; data and error hold until the next completion.
    always_ff @(posedge PCLK) begin
        if (PRST) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done || abort;
            if (done) begin
                rsp_err   <= sel_err;
                rsp_rdata <= PWRITE ? '0 : sel_rdata;
            end else if (abort) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule
